// File: rtl/rr_count_scheduler_pkg.sv
// Shared types and default sizes for the round-robin counter scheduler.
// Optional feature macro used by the top: RR_COUNT_SCHEDULER_ABORT_EN.
package rr_count_pkg;

  // Scheduler sequencing: wait for a request, run the counter, signal completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default number of requesters and counter width.
  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;

  // Width of a requester index; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_count_scheduler_arbiter.sv
// Combinational round-robin picker: the first asserted request found when
// searching upward from the position just after the pointer, wrapping around.
module rr_arbiter
  import rr_count_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  // Scan from farthest to nearest so the nearest set request is written last and wins.
  always_comb begin
    int w_idx;
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (req[w_idx]) begin
        winner = IW'(w_idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_count_scheduler.sv
// One shared down-counter time-multiplexed among NREQ requesters.
// A winner is picked round-robin, its load value is captured, the counter runs
// to zero, a done pulse goes back to the winner, and the resource is released.
// Optional feature macro: RR_COUNT_SCHEDULER_ABORT_EN (adds abort/aborted).
module rr_count_scheduler
  import rr_count_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] load_val,
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cnt
);

  localparam int IW = idx_width(NREQ);

  state_t            r_state, w_state_next;
  logic [IW-1:0]     r_ptr, w_ptr_next;
  logic [IW-1:0]     r_owner, w_owner_next;
  logic [NREQ-1:0]   r_gnt, w_gnt_next;
  logic [NREQ-1:0]   r_done, w_done_next;
  logic [W-1:0]      r_cnt, w_cnt_next;
  logic              r_aborted, w_aborted_next;

  logic [IW-1:0]     w_winner;
  logic              w_valid;
  logic [W-1:0]      w_load [NREQ];

  // Unpack the flat load-value bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_load[gi] = load_val[gi*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arbiter (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // State register; reset drops any grant in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= IW'(NREQ - 1);
      r_owner   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_owner   <= w_owner_next;
      r_gnt     <= w_gnt_next;
      r_done    <= w_done_next;
      r_cnt     <= w_cnt_next;
      r_aborted <= w_aborted_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down in COUNT, release in DONE.
  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_owner_next   = r_owner;
    w_gnt_next     = r_gnt;
    w_done_next    = '0;
    w_cnt_next     = r_cnt;
    w_aborted_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_next   = NREQ'(1) << w_winner;
          w_cnt_next   = w_load[w_winner];
          w_owner_next = w_winner;
          w_state_next = COUNT;
        end
      end
      COUNT: begin
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
        if (abort) begin
          // Early termination keeps the counter value for inspection.
          w_done_next    = r_gnt;
          w_aborted_next = 1'b1;
          w_state_next   = DONE;
        end else
`endif
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - W'(1);
        end else begin
          w_done_next  = r_gnt;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // The pointer moves to the last owner so it gets lowest priority next.
        w_gnt_next   = '0;
        w_ptr_next   = r_owner;
        w_state_next = IDLE;
      end
      default: begin
        w_gnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = (r_state != IDLE);
  assign cnt  = r_cnt;
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
  assign aborted = r_aborted;
`endif

endmodule

// File: tb/tb_rr_count_scheduler.sv
// Self-checking bench for rr_count_scheduler: directed scenarios followed by
// random traffic, compared every cycle against a transaction-level model that
// expands each grant into its expected per-cycle output timeline.
module tb_rr_count_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] load_val = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      cnt;
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rr_count_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt      (cnt)
  );

  // Expected outputs after one clock edge; kind: 0 idle, 1 counting, 2 done.
  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    cnt;
    logic            done;
    logic            busy;
    logic            abrt;
    int              kind;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_ptr;

  function automatic exp_t mk(logic [NREQ-1:0] g, logic [W-1:0] c, logic d,
                              logic b, logic a, int k);
    exp_t e;
    e.gnt = g; e.cnt = c; e.done = d; e.busy = b; e.abrt = a; e.kind = k;
    return e;
  endfunction

  // Advance the model by one edge using the inputs the DUT saw at that edge.
  task automatic model_step();
    int win;
    int v;
    logic [NREQ-1:0] g;
    if (rst) begin
      q.delete();
      m_ptr = NREQ - 1;
      cur = mk('0, '0, 1'b0, 1'b0, 1'b0, 0);
      return;
    end
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
    if (abort && cur.kind == 1) begin
      q.delete();
      cur = mk(cur.gnt, cur.cnt, 1'b1, 1'b1, 1'b1, 2);
      q.push_back(mk('0, cur.cnt, 1'b0, 1'b0, 1'b0, 0));
      return;
    end
`endif
    if (q.size() > 0) begin
      cur = q.pop_front();
      return;
    end
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (win < 0 && req[i]) win = i;
    end
    if (win >= 0) begin
      v = int'(load_val[win*W +: W]);
      g = '0;
      g[win] = 1'b1;
      cur = mk(g, W'(v), 1'b0, 1'b1, 1'b0, 1);
      for (int c = v - 1; c >= 0; c--) q.push_back(mk(g, W'(c), 1'b0, 1'b1, 1'b0, 1));
      q.push_back(mk(g, '0, 1'b1, 1'b1, 1'b0, 2));
      q.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0, 0));
      m_ptr = win;
    end else begin
      cur = mk('0, cur.cnt, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
  endtask

  // One clock: update the model at the edge, sample the DUT just after it.
  task automatic step();
    logic [NREQ-1:0] exp_done;
    @(posedge clk);
    model_step();
    #1;
    exp_done = cur.done ? cur.gnt : '0;
    check("gnt",  32'(gnt),  32'(cur.gnt));
    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(cur.busy));
    check("cnt",  32'(cnt),  32'(cur.cnt));
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
    check("aborted", 32'(aborted), 32'(cur.abrt));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_load(input int idx, input int v);
    load_val[idx*W +: W] = W'(v);
  endtask

  initial begin
    bit hit;
    m_ptr = NREQ - 1;
    cur = mk('0, '0, 1'b0, 1'b0, 1'b0, 0);

    // Reset state.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(1);

    // Single requester, load 3.
    set_load(0, 3);
    req = 4'b0001;
    run(1);
    req = 4'b0000;
    run(7);

    // Contention: all requesting, all loads 1.
    for (int i = 0; i < NREQ; i++) set_load(i, 1);
    req = 4'b1111;
    run(22);
    req = 4'b0000;
    run(4);

    // Zero load on requester 2.
    set_load(2, 0);
    req = 4'b0100;
    run(1);
    req = 4'b0000;
    run(4);

    // Full-range count on requester 1, with load changes after grant ignored.
    set_load(1, 15);
    req = 4'b0010;
    run(1);
    req = 4'b0000;
    set_load(1, 2);
    run(20);

    // Reset in the middle of a count.
    set_load(0, 10);
    req = 4'b0001;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (cnt == 4'd6) hit = 1'b1;
      else step();
    end
    check("reach_cnt6", 32'(hit), 32'(1));
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    req = 4'b0000;
    run(12);

`ifdef RR_COUNT_SCHEDULER_ABORT_EN
    // Abort while counting on requester 3.
    set_load(3, 9);
    req = 4'b1000;
    run(1);
    req = 4'b0000;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (cnt == 4'd5) hit = 1'b1;
      else step();
    end
    check("reach_cnt5", 32'(hit), 32'(1));
    abort = 1'b1;
    run(1);
    abort = 1'b0;
    run(4);
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      req = NREQ'($urandom);
      load_val = (NREQ*W)'($urandom);
      rst = ($urandom_range(0, 63) == 0);
`ifdef RR_COUNT_SCHEDULER_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    rst = 1'b0;
    req = '0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
